// File: rtl/ghost_motion_engine.sv
// Ghost motion engine.
// Moves NUM_GHOSTS sprites once per video frame. A single datapath is
// time-shared across the ghosts: on each accepted startOfFrame the FSM
// sweeps ghost 0..NUM_GHOSTS-1, spending one UPDATE cycle (eaten / respawn /
// wall bounce / random turn / move) and one CLAMP cycle (screen limits) on
// each. Positions are signed fixed point with FP_SHIFT fraction bits; the
// pixel outputs are the floor of the fixed-point value.

module ghost_motion_engine #(
  parameter int          NUM_GHOSTS     = 4,
  parameter int          FP_SHIFT       = 6,
  parameter int          SPEED          = 60,
  parameter int          OBJ_W          = 32,
  parameter int          OBJ_H          = 32,
  parameter int          HOME_X         = 300,
  parameter int          HOME_Y         = 220,
  parameter int          TURN_FRAMES    = 150,
  parameter int          RESPAWN_FRAMES = 64,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic                           restart,
  input  logic                           freeze,
  input  logic                           frightened,
  input  logic [4*NUM_GHOSTS-1:0]        hit_edge,
  input  logic [NUM_GHOSTS-1:0]          eaten,
  output logic signed [11*NUM_GHOSTS-1:0] topLeftX,
  output logic signed [11*NUM_GHOSTS-1:0] topLeftY,
  output logic [2*NUM_GHOSTS-1:0]        dir,
  output logic                           busy
);

  // ---------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------
  localparam int PW = 11 + FP_SHIFT;
  localparam int GW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam int FW = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;
  localparam int RW = (RESPAWN_FRAMES > 0) ? $clog2(RESPAWN_FRAMES + 1) : 1;

  typedef logic signed [PW-1:0] fix_t;

  // Direction encoding: 0 right, 1 down, 2 left, 3 up. Reversal is dir ^ 2,
  // a quarter turn is dir +/- 1 modulo 4.
  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  localparam fix_t ONE_PX  = fix_t'(1 << FP_SHIFT);
  localparam fix_t SPEED_N = fix_t'(SPEED);
  localparam fix_t SPEED_F = fix_t'(SPEED >> 1);
  localparam fix_t HOME_XF = fix_t'(HOME_X << FP_SHIFT);
  localparam fix_t HOME_YF = fix_t'(HOME_Y << FP_SHIFT);
  localparam fix_t X_MIN   = fix_t'(1 << FP_SHIFT);
  localparam fix_t X_MAX   = fix_t'((638 - OBJ_W) << FP_SHIFT);
  localparam fix_t Y_MIN   = fix_t'(1 << FP_SHIFT);
  localparam fix_t Y_MAX   = fix_t'((478 - OBJ_H) << FP_SHIFT);

  localparam logic [GW-1:0] LAST_GHOST = GW'(NUM_GHOSTS - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(TURN_FRAMES - 1);
  localparam logic [RW-1:0] RESP_LOAD  = RW'(RESPAWN_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_UPDATE,
    S_CLAMP
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t            state_q;
  state_t            state_d;
  logic [GW-1:0]     gidx;
  logic [FW-1:0]     frame_cnt;
  logic [15:0]       lfsr;

  fix_t              pos_x   [NUM_GHOSTS];
  fix_t              pos_y   [NUM_GHOSTS];
  logic [1:0]        dir_q   [NUM_GHOSTS];
  logic [RW-1:0]     resp_q  [NUM_GHOSTS];
  logic [3:0]        edge_lat[NUM_GHOSTS];
  logic [NUM_GHOSTS-1:0] eaten_lat;

  logic              last_ghost;
  logic              turn_frame;
  logic              lfsr_fb;

  assign last_ghost = (gidx == LAST_GHOST);
  assign turn_frame = (frame_cnt == LAST_FRAME);
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register; restart returns to IDLE like a reset.
  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)      state_q <= S_IDLE;
    else if (restart) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Next-state and busy decode: two cycles per ghost once a frame starts.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a value held and no latch is inferred.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      S_IDLE:     state_d = S_WAIT_SOF;
      S_WAIT_SOF: if (startOfFrame && !freeze) state_d = S_UPDATE;
      S_UPDATE: begin
        busy    = 1'b1;
        state_d = S_CLAMP;
      end
      S_CLAMP: begin
        busy    = 1'b1;
        state_d = last_ghost ? S_WAIT_SOF : S_UPDATE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Ghost index, frame counter and LFSR; the latter two step once per sweep.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      gidx      <= '0;
      frame_cnt <= '0;
      lfsr      <= LFSR_SEED;
    end else if (restart) begin
      gidx      <= '0;
      frame_cnt <= '0;
      lfsr      <= LFSR_SEED;
    end else if (state_q == S_CLAMP) begin
      if (last_ghost) begin
        gidx      <= '0;
        frame_cnt <= turn_frame ? '0 : frame_cnt + FW'(1);
        lfsr      <= {lfsr[14:0], lfsr_fb};
      end else begin
        gidx <= gidx + GW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sticky event latches
  // ---------------------------------------------------------------------

  // Wall and eaten events accumulate between visits; the visit consumes
  // them, but an event arriving in that same cycle is kept for next frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int g = 0; g < NUM_GHOSTS; g++) edge_lat[g] <= '0;
      eaten_lat <= '0;
    end else if (restart) begin
      for (int g = 0; g < NUM_GHOSTS; g++) edge_lat[g] <= '0;
      eaten_lat <= '0;
    end else begin
      for (int g = 0; g < NUM_GHOSTS; g++) begin
        if (state_q == S_UPDATE && gidx == GW'(g)) begin
          edge_lat[g]  <= hit_edge[4*g +: 4];
          eaten_lat[g] <= eaten[g];
        end else begin
          edge_lat[g]  <= edge_lat[g] | hit_edge[4*g +: 4];
          eaten_lat[g] <= eaten_lat[g] | eaten[g];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shared datapath for the ghost selected by gidx
  // ---------------------------------------------------------------------
  fix_t          cur_x, cur_y, spd;
  logic [1:0]    cur_dir;
  logic [RW-1:0] cur_resp;
  logic [3:0]    cur_edge;
  logic          facing_hit;
  fix_t          upd_x, upd_y;
  logic [1:0]    upd_dir;
  logic [RW-1:0] upd_resp;
  fix_t          clp_x, clp_y;
  logic [1:0]    clp_dir;

  // UPDATE step: eaten > parked > wall bounce > random turn, then move.
  always_comb begin
    cur_x    = pos_x[gidx];
    cur_y    = pos_y[gidx];
    cur_dir  = dir_q[gidx];
    cur_resp = resp_q[gidx];
    cur_edge = edge_lat[gidx];
    spd      = frightened ? SPEED_F : SPEED_N;

    // Edge bits are {left, top, right, bottom}; pick the one ahead of us.
    case (cur_dir)
      DIR_RIGHT: facing_hit = cur_edge[1];
      DIR_DOWN:  facing_hit = cur_edge[0];
      DIR_LEFT:  facing_hit = cur_edge[3];
      default:   facing_hit = cur_edge[2];
    endcase

    upd_x    = cur_x;
    upd_y    = cur_y;
    upd_dir  = cur_dir;
    upd_resp = cur_resp;

    if (eaten_lat[gidx]) begin
      upd_x    = HOME_XF;
      upd_y    = HOME_YF;
      upd_resp = RESP_LOAD;
    end else if (cur_resp != '0) begin
      upd_resp = cur_resp - RW'(1);
    end else begin
      if (facing_hit) begin
        // Back off one pixel out of the wall before moving the other way.
        upd_dir = cur_dir ^ 2'd2;
        case (cur_dir)
          DIR_RIGHT: upd_x = cur_x - ONE_PX;
          DIR_DOWN:  upd_y = cur_y - ONE_PX;
          DIR_LEFT:  upd_x = cur_x + ONE_PX;
          default:   upd_y = cur_y + ONE_PX;
        endcase
      end else if (turn_frame) begin
        upd_dir = lfsr[gidx] ? cur_dir + 2'd1 : cur_dir - 2'd1;
      end
      case (upd_dir)
        DIR_RIGHT: upd_x = upd_x + spd;
        DIR_DOWN:  upd_y = upd_y + spd;
        DIR_LEFT:  upd_x = upd_x - spd;
        default:   upd_y = upd_y - spd;
      endcase
    end
  end

  // CLAMP step: keep the sprite on screen, bouncing if it was heading out.
  always_comb begin
    clp_x   = cur_x;
    clp_y   = cur_y;
    clp_dir = cur_dir;
    if (cur_x < X_MIN) begin
      clp_x = X_MIN;
      if (cur_dir == DIR_LEFT) clp_dir = DIR_RIGHT;
    end else if (cur_x > X_MAX) begin
      clp_x = X_MAX;
      if (cur_dir == DIR_RIGHT) clp_dir = DIR_LEFT;
    end
    if (cur_y < Y_MIN) begin
      clp_y = Y_MIN;
      if (cur_dir == DIR_UP) clp_dir = DIR_DOWN;
    end else if (cur_y > Y_MAX) begin
      clp_y = Y_MAX;
      if (cur_dir == DIR_DOWN) clp_dir = DIR_UP;
    end
  end

  // Per-ghost registers, written back for the ghost under service.
  // NOTE: the ghost arrays are reset because each entry has a distinct,
  // architecturally visible start position and direction.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int g = 0; g < NUM_GHOSTS; g++) begin
        pos_x[g]  <= fix_t'((HOME_X + g * OBJ_W) << FP_SHIFT);
        pos_y[g]  <= HOME_YF;
        dir_q[g]  <= 2'(g % 4);
        resp_q[g] <= '0;
      end
    end else if (restart) begin
      for (int g = 0; g < NUM_GHOSTS; g++) begin
        pos_x[g]  <= fix_t'((HOME_X + g * OBJ_W) << FP_SHIFT);
        pos_y[g]  <= HOME_YF;
        dir_q[g]  <= 2'(g % 4);
        resp_q[g] <= '0;
      end
    end else if (state_q == S_UPDATE) begin
      pos_x[gidx]  <= upd_x;
      pos_y[gidx]  <= upd_y;
      dir_q[gidx]  <= upd_dir;
      resp_q[gidx] <= upd_resp;
    end else if (state_q == S_CLAMP) begin
      pos_x[gidx] <= clp_x;
      pos_y[gidx] <= clp_y;
      dir_q[gidx] <= clp_dir;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: pixel = floor(fixed >> FP_SHIFT), i.e. the integer bits.
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_out
    assign topLeftX[11*g +: 11] = pos_x[g][FP_SHIFT +: 11];
    assign topLeftY[11*g +: 11] = pos_y[g][FP_SHIFT +: 11];
    assign dir[2*g +: 2]        = dir_q[g];
  end

endmodule

// File: tb/tb_ghost_motion_engine.sv
// Testbench for ghost_motion_engine: directed scenarios plus randomized
// frames, checked against a frame-level reference model of the ghost rules.

module tb_ghost_motion_engine;

  localparam int NG   = 4;
  localparam int FP   = 6;
  localparam int SPD  = 60;
  localparam int OW   = 32;
  localparam int OH   = 32;
  localparam int HX   = 300;
  localparam int HY   = 220;
  localparam int TF   = 150;
  localparam int RF   = 64;
  localparam int SEED = 'hACE1;

  localparam int ONE  = 1 << FP;
  localparam int XMIN = ONE;
  localparam int XMAX = (638 - OW) * ONE;
  localparam int YMIN = ONE;
  localparam int YMAX = (478 - OH) * ONE;

  logic                   clk = 1'b0;
  logic                   resetN = 1'b0;
  logic                   startOfFrame = 1'b0;
  logic                   restart = 1'b0;
  logic                   freeze = 1'b0;
  logic                   frightened = 1'b0;
  logic [4*NG-1:0]        hit_edge = '0;
  logic [NG-1:0]          eaten = '0;
  logic signed [11*NG-1:0] topLeftX;
  logic signed [11*NG-1:0] topLeftY;
  logic [2*NG-1:0]        dir;
  logic                   busy;

  int n_tests = 0;
  int n_fail  = 0;

  ghost_motion_engine #(
    .NUM_GHOSTS(NG), .FP_SHIFT(FP), .SPEED(SPD), .OBJ_W(OW), .OBJ_H(OH),
    .HOME_X(HX), .HOME_Y(HY), .TURN_FRAMES(TF), .RESPAWN_FRAMES(RF),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .restart(restart), .freeze(freeze), .frightened(frightened),
    .hit_edge(hit_edge), .eaten(eaten),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .dir(dir), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (one call = one whole frame) --------
  int mx[NG], my[NG], md[NG], mr[NG], pend_edge[NG], pend_eat[NG];
  int mframe, mlfsr;
  int dxs[4] = '{1, 0, -1, 0};
  int dys[4] = '{0, 1, 0, -1};
  int face[4] = '{1, 0, 3, 2};   // edge bit lying ahead of each direction

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < NG; g++) begin
      mx[g] = (HX + g * OW) * ONE;
      my[g] = HY * ONE;
      md[g] = g % 4;
      mr[g] = 0;
      pend_edge[g] = 0;
      pend_eat[g]  = 0;
    end
    mframe = 0;
    mlfsr  = SEED;
  endtask

  task automatic model_sweep(input bit fr);
    int spd, fb;
    spd = fr ? SPD / 2 : SPD;
    for (int g = 0; g < NG; g++) begin
      if (pend_eat[g] != 0) begin
        mx[g] = HX * ONE;
        my[g] = HY * ONE;
        mr[g] = RF;
      end else if (mr[g] > 0) begin
        mr[g] = mr[g] - 1;
      end else begin
        if (((pend_edge[g] >> face[md[g]]) & 1) == 1) begin
          mx[g] = mx[g] - ONE * dxs[md[g]];
          my[g] = my[g] - ONE * dys[md[g]];
          md[g] = (md[g] + 2) % 4;
        end else if (mframe == TF - 1) begin
          md[g] = (((mlfsr >> g) & 1) == 1) ? (md[g] + 1) % 4 : (md[g] + 3) % 4;
        end
        mx[g] = mx[g] + spd * dxs[md[g]];
        my[g] = my[g] + spd * dys[md[g]];
      end
      if (mx[g] < XMIN) begin mx[g] = XMIN; if (md[g] == 2) md[g] = 0; end
      else if (mx[g] > XMAX) begin mx[g] = XMAX; if (md[g] == 0) md[g] = 2; end
      if (my[g] < YMIN) begin my[g] = YMIN; if (md[g] == 3) md[g] = 1; end
      else if (my[g] > YMAX) begin my[g] = YMAX; if (md[g] == 1) md[g] = 3; end
      pend_edge[g] = 0;
      pend_eat[g]  = 0;
    end
    mframe = (mframe + 1) % TF;
    fb = ((mlfsr >> 15) ^ (mlfsr >> 13) ^ (mlfsr >> 12) ^ (mlfsr >> 10)) & 1;
    mlfsr = ((mlfsr << 1) | fb) & 'hFFFF;
  endtask

  // ---------------- DUT access helpers ----------------------------------
  function automatic int px_x(input int g);
    return int'($signed(topLeftX[11*g +: 11]));
  endfunction
  function automatic int px_y(input int g);
    return int'($signed(topLeftY[11*g +: 11]));
  endfunction
  function automatic int dir_of(input int g);
    return int'(dir[2*g +: 2]);
  endfunction

  task automatic compare_all(input string tag);
    for (int g = 0; g < NG; g++) begin
      check($sformatf("%s x%0d", tag, g), px_x(g), mx[g] >>> FP);
      check($sformatf("%s y%0d", tag, g), px_y(g), my[g] >>> FP);
      check($sformatf("%s dir%0d", tag, g), dir_of(g), md[g]);
    end
  endtask

  // One-cycle pulse on hit_edge/eaten while idle; noted as pending in model.
  task automatic apply_inputs(input logic [4*NG-1:0] e, input logic [NG-1:0] t);
    hit_edge = e;
    eaten    = t;
    for (int g = 0; g < NG; g++) begin
      pend_edge[g] |= int'(e[4*g +: 4]);
      pend_eat[g]  |= int'(t[g]);
    end
    @(negedge clk);
    hit_edge = '0;
    eaten    = '0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  // mode 0: plain frame, 1: extra startOfFrame mid-sweep,
  // 2: freeze raised mid-sweep, 3: ghost0 right-edge hit in its own UPDATE cycle
  task automatic run_sweep(input int mode, input string tag);
    int n, idle_busy;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      startOfFrame = (mode == 1 && n == 3);
      if (mode == 2 && n == 2) freeze = 1'b1;
      if (mode == 3) hit_edge = (n == 1) ? 16'h0002 : '0;
      @(negedge clk);
    end
    startOfFrame = 1'b0;
    freeze       = 1'b0;
    hit_edge     = '0;
    check({tag, " busy_len"}, n, 2 * NG);
    model_sweep(frightened);
    if (mode == 3) pend_edge[0] |= 2;
    compare_all(tag);
    if (mode == 1) begin
      idle_busy = 0;
      for (int i = 0; i < 3; i++) begin
        if (busy !== 1'b0) idle_busy++;
        @(negedge clk);
      end
      check({tag, " no_resweep"}, idle_busy, 0);
    end
  endtask

  // ---------------- main sequence ---------------------------------------
  initial begin
    int busy_seen;
    logic [4*NG-1:0] e;
    logic [NG-1:0]   t;

    model_reset();
    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    compare_all("reset");

    // Release reset with startOfFrame already high: it lands in IDLE.
    resetN = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0) busy_seen++;
      @(negedge clk);
    end
    check("sof_in_idle busy", busy_seen, 0);

    // Two plain frames: 19200 -> 19260 (px 300) -> 19320 (px 301).
    run_sweep(0, "frame1");
    check("frame1 x0_px", px_x(0), 300);
    run_sweep(0, "frame2");
    check("frame2 x0_px", px_x(0), 301);

    // Frightened: half speed.
    frightened = 1'b1;
    run_sweep(0, "fright");
    frightened = 1'b0;

    // Right-edge hit on ghost0: reverse, back off 64, move 60 left.
    do_restart();
    compare_all("restart");
    apply_inputs(16'h0002, '0);
    run_sweep(0, "bounce");
    check("bounce dir0", dir_of(0), 2);
    check("bounce x0_px", px_x(0), (19200 - 64 - 60) >>> FP);

    // Hit arriving in ghost0's own UPDATE cycle is kept for the next frame.
    do_restart();
    run_sweep(3, "retain_a");
    check("retain_a dir0", dir_of(0), 0);
    run_sweep(0, "retain_b");
    check("retain_b dir0", dir_of(0), 2);

    // Ignored starts: during busy, and with freeze; freeze mid-sweep is harmless.
    run_sweep(1, "sof_busy");
    run_sweep(2, "freeze_mid");
    freeze = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0) busy_seen++;
      @(negedge clk);
    end
    freeze = 1'b0;
    check("frozen busy", busy_seen, 0);
    compare_all("frozen");

    // Eaten ghost2: home, parked 64 frames, moves on the 65th.
    do_restart();
    apply_inputs('0, 4'b0100);
    run_sweep(0, "eaten");
    check("eaten x2_px", px_x(2), HX);
    check("eaten y2_px", px_y(2), HY);
    for (int k = 1; k <= RF; k++) run_sweep(0, $sformatf("parked%0d", k));
    check("parked x2_px", px_x(2), HX);
    run_sweep(0, "respawn");
    check("respawn x2_px", px_x(2), (HX * ONE - SPD) >>> FP);

    // Steering: keep every ghost heading left or up so all reach the low
    // walls and exercise clamp bounces; spans several turn frames.
    do_restart();
    for (int k = 0; k < 400; k++) begin
      e = '0;
      for (int g = 0; g < NG; g++) begin
        if (md[g] == 0) e[4*g + 1] = 1'b1;
        if (md[g] == 1) e[4*g + 0] = 1'b1;
      end
      apply_inputs(e, '0);
      run_sweep(0, "steer");
    end

    // Randomized frames.
    do_restart();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 99) == 0) do_restart();
      e = '0;
      t = '0;
      for (int g = 0; g < NG; g++) begin
        if ($urandom_range(0, 3) == 0) e[4*g +: 4] = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 39) == 0) t[g] = 1'b1;
      end
      apply_inputs(e, t);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      frightened = 1'($urandom_range(0, 1));
      run_sweep($urandom_range(0, 2), "rand");
      frightened = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
